// File: rtl/proc_pkg.sv
// Shared types for the multi-cycle HMMM sequencer: state encoding, opcode
// and branch-condition codes, and the branch condition evaluator.
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_NOP   = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b0111;

  localparam logic [1:0] CC_EQ0 = 2'b00;
  localparam logic [1:0] CC_NE0 = 2'b01;
  localparam logic [1:0] CC_GT0 = 2'b10;
  localparam logic [1:0] CC_LT0 = 2'b11;

  function automatic logic branch_cond(input logic [1:0] cc, input logic neg, input logic zero);
    logic r;
    r = 1'b0;
    case (cc)
      CC_EQ0:  r = zero;
      CC_NE0:  r = !zero;
      CC_GT0:  r = !neg && !zero;
      default: r = neg;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait-cycle counter for an outstanding req; expired flags the last
// cycle the requester may still be acked before it is declared dead.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 4-bit HMMM core: fetch over req/ack,
// decode, then one datapath phase per state, with halt and ack timeout.
module multicycle_ctrl
  import proc_pkg::*;
#(
  parameter int INSTR_W     = 10,
  parameter int DATA_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] instr,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  branch_reg_val,
  output logic               ir_en,
  output logic               pc_en,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               alu_op,
  output logic               halted,
  output logic               err,
  output logic [2:0]         state_o
);

  state_t     state, next_state;
  logic [3:0] opcode;
  logic       req_active, ack_cur, expired, taken;

  // Only the ack belonging to the current request phase counts.
  assign req_active = (state == S_FETCH) || (state == S_MEM);
  assign ack_cur    = (state == S_FETCH) ? imem_ack :
                      (state == S_MEM)   ? dmem_ack : 1'b0;

  ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!req_active || ack_cur),
    .inc     (req_active && !ack_cur),
    .expired (expired)
  );

  assign taken = opcode[2] ||
                 branch_cond(opcode[1:0], branch_reg_val[DATA_W-1], branch_reg_val == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      opcode <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && imem_ack) opcode <= instr[INSTR_W-1 -: 4];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run) next_state = S_FETCH;
      S_FETCH:  if (imem_ack) next_state = S_DECODE;
                else if (expired) next_state = S_ERROR;
      S_DECODE: begin
        if (opcode[3])                 next_state = S_BRANCH;
        else if (opcode[3:2] == 2'b00) next_state = S_EXEC;
        else if (opcode == OP_NOP)     next_state = S_FETCH;
        else if (opcode == OP_HALT)    next_state = S_HALT;
        else                           next_state = S_MEM;
      end
      S_EXEC:   next_state = S_FETCH;
      S_MEM:    if (dmem_ack) next_state = S_FETCH;
                else if (expired) next_state = S_ERROR;
      S_BRANCH: next_state = S_FETCH;
      default:  next_state = state;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
        pc_en    = imem_ack;
      end
      S_EXEC: begin
        reg_write = 1'b1;
        alu_src   = opcode[1];
        alu_op    = opcode[0];
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = opcode[0];
        reg_write  = dmem_ack && !opcode[0];
        mem_to_reg = dmem_ack && !opcode[0];
      end
      // Absolute target replaces the PC+1 already taken during fetch.
      S_BRANCH: begin
        pc_en  = taken;
        pc_src = taken;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: err    = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[INSTR_W-5:0];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, ALU, load/store wait states,
// branch conditions, ack timeout, halt and reset during a data request.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, imem_ack, dmem_ack;
  logic [9:0] instr;
  logic [3:0] branch_reg_val;
  logic       imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src;
  logic       reg_write, mem_to_reg, alu_src, alu_op, halted, err;
  logic [2:0] state_o;
  logic [11:0] outs;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [11:0] IREQ = 12'h800, DREQ = 12'h400, DWE  = 12'h200, IR   = 12'h100;
  localparam logic [11:0] PCEN = 12'h080, PCS  = 12'h040, RW   = 12'h020, M2R  = 12'h010;
  localparam logic [11:0] ASRC = 12'h008, AOP  = 12'h004, HLT  = 12'h002, ERR  = 12'h001;

  multicycle_ctrl #(.INSTR_W(10), .DATA_W(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_reg_val(branch_reg_val),
    .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .halted(halted), .err(err), .state_o(state_o)
  );

  assign outs = {imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src,
                 reg_write, mem_to_reg, alu_src, alu_op, halted, err};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = '0; branch_reg_val = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    instr = 10'b0111_000000; branch_reg_val = '0;
    tick(); tick(); #1;
    total_cnt++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else pass_cnt++;
    total_cnt++; if (outs !== 12'h000) $display("FAIL reset_outs got %03h want 000", outs); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; instr = 10'b0011_01_10_11; #1;
    total_cnt++; if ({state_o, outs} !== {3'd0, 12'h000}) $display("FAIL alu_c0 got %0d/%03h want 0/000", state_o, outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd1, IREQ|IR|PCEN}) $display("FAIL alu_c1 got %0d/%03h want 1/%03h", state_o, outs, IREQ|IR|PCEN); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd2, 12'h000}) $display("FAIL alu_c2 got %0d/%03h want 2/000", state_o, outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd3, RW|ASRC|AOP}) $display("FAIL alu_c3 got %0d/%03h want 3/%03h", state_o, outs, RW|ASRC|AOP); else pass_cnt++;
    tick(); imem_ack = 1'b0; #1;
    total_cnt++; if ({state_o, outs} !== {3'd1, IREQ}) $display("FAIL alu_c4 got %0d/%03h want 1/%03h", state_o, outs, IREQ); else pass_cnt++;
  endtask

  task automatic test_load_store();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; instr = 10'b0100_000000;
    tick(); #1;
    total_cnt++; if (outs !== (IREQ|IR|PCEN)) $display("FAIL ld_fetch got %03h want %03h", outs, IREQ|IR|PCEN); else pass_cnt++;
    tick(); imem_ack = 1'b0; #1;
    total_cnt++; if ({state_o, outs} !== {3'd2, 12'h000}) $display("FAIL ld_decode got %0d/%03h want 2/000", state_o, outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd4, DREQ}) $display("FAIL ld_wait1 got %0d/%03h want 4/%03h", state_o, outs, DREQ); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd4, DREQ}) $display("FAIL ld_wait2 got %0d/%03h want 4/%03h", state_o, outs, DREQ); else pass_cnt++;
    tick(); dmem_ack = 1'b1; #1;
    total_cnt++; if (outs !== (DREQ|RW|M2R)) $display("FAIL ld_ack got %03h want %03h", outs, DREQ|RW|M2R); else pass_cnt++;
    tick(); dmem_ack = 1'b0; imem_ack = 1'b1; instr = 10'b0101_000000; #1;
    total_cnt++; if ({state_o, outs} !== {3'd1, IREQ|IR|PCEN}) $display("FAIL st_fetch got %0d/%03h want 1/%03h", state_o, outs, IREQ|IR|PCEN); else pass_cnt++;
    tick(); imem_ack = 1'b0; dmem_ack = 1'b1; #1;
    total_cnt++; if ({state_o, outs} !== {3'd2, 12'h000}) $display("FAIL st_decode_ack_ignored got %0d/%03h want 2/000", state_o, outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd4, DREQ|DWE}) $display("FAIL st_mem got %0d/%03h want 4/%03h", state_o, outs, DREQ|DWE); else pass_cnt++;
    tick(); dmem_ack = 1'b0; #1;
    total_cnt++; if ({state_o, outs} !== {3'd1, IREQ}) $display("FAIL st_done got %0d/%03h want 1/%03h", state_o, outs, IREQ); else pass_cnt++;
  endtask

  task automatic run_branch(input logic [9:0] ins, input logic [3:0] val, input logic tk);
    logic [11:0] exp;
    exp = tk ? (PCEN|PCS) : 12'h000;
    do_reset();
    run = 1'b1; imem_ack = 1'b1; instr = ins;
    tick(); tick(); imem_ack = 1'b0;
    tick(); branch_reg_val = val; #1;
    total_cnt++; if ({state_o, outs} !== {3'd5, exp}) $display("FAIL branch_%03h_%h got %0d/%03h want 5/%03h", ins, val, state_o, outs, exp); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (state_o !== 3'd1) $display("FAIL branch_ret_%03h got %0d want 1", ins, state_o); else pass_cnt++;
  endtask

  task automatic test_branch();
    run_branch(10'b1010_000000, 4'b0011, 1'b1);
    run_branch(10'b1010_000000, 4'b1000, 1'b0);
    run_branch(10'b1010_000000, 4'b0000, 1'b0);
    run_branch(10'b1100_000000, 4'b0000, 1'b1);
    run_branch(10'b1000_000000, 4'b0000, 1'b1);
    run_branch(10'b1001_000000, 4'b0000, 1'b0);
    run_branch(10'b1011_000000, 4'b1000, 1'b1);
    run_branch(10'b1011_000000, 4'b0111, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      total_cnt++; if ({state_o, outs} !== {3'd1, IREQ}) $display("FAIL to_wait%0d got %0d/%03h want 1/%03h", i, state_o, outs, IREQ); else pass_cnt++;
    end
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd7, ERR}) $display("FAIL to_error got %0d/%03h want 7/%03h", state_o, outs, ERR); else pass_cnt++;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      total_cnt++; if ({state_o, outs} !== {3'd7, ERR}) $display("FAIL to_sticky%0d got %0d/%03h want 7/%03h", i, state_o, outs, ERR); else pass_cnt++;
    end
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) begin imem_ack = 1'b1; instr = 10'b0110_000000; end
      #1;
      total_cnt++;
      if ({state_o, outs} !== {3'd1, (i == 15) ? (IREQ|IR|PCEN) : IREQ})
        $display("FAIL to_late%0d got %0d/%03h", i, state_o, outs);
      else pass_cnt++;
    end
    tick(); imem_ack = 1'b0; #1;
    total_cnt++; if ({state_o, outs} !== {3'd2, 12'h000}) $display("FAIL to_late_decode got %0d/%03h want 2/000", state_o, outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd1, IREQ}) $display("FAIL to_late_nop got %0d/%03h want 1/%03h", state_o, outs, IREQ); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; instr = 10'b0111_000000;
    tick(); tick(); imem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); imem_ack = i[0]; #1;
      total_cnt++; if ({state_o, outs} !== {3'd6, HLT}) $display("FAIL halt%0d got %0d/%03h want 6/%03h", i, state_o, outs, HLT); else pass_cnt++;
    end
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b0; #1;
    total_cnt++; if ({state_o, outs} !== {3'd0, 12'h000}) $display("FAIL halt_reset got %0d/%03h want 0/000", state_o, outs); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; instr = 10'b0101_000000;
    tick(); tick(); imem_ack = 1'b0;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd4, DREQ|DWE}) $display("FAIL mid_mem got %0d/%03h want 4/%03h", state_o, outs, DREQ|DWE); else pass_cnt++;
    reset = 1'b1;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd0, 12'h000}) $display("FAIL mid_reset got %0d/%03h want 0/000", state_o, outs); else pass_cnt++;
    reset = 1'b0; run = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b1; #1;
    total_cnt++; if (outs !== 12'h000) $display("FAIL mid_late_ack got %03h want 000", outs); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({state_o, outs} !== {3'd0, 12'h000}) $display("FAIL mid_idle got %0d/%03h want 0/000", state_o, outs); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
